// File: rtl/cpu_trace_buffer.sv
// Circular capture history of stackCPU results with back/forward browsing.
// The displayed entry and all status outputs are registered one cycle after capture/navigation.
module cpu_trace_buffer #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int PTR_W       = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cap_valid,
    input  logic [PC_WIDTH-1:0]          cap_pc,
    input  logic [INSTR_WIDTH-1:0]       cap_instr,
    input  logic signed [DATA_WIDTH-1:0] cap_result,
    input  logic                         cap_halt,
    input  logic                         cap_error,
    input  logic                         nav_back,
    input  logic                         nav_fwd,
    input  logic                         nav_live,
    output logic                         disp_valid,
    output logic [PC_WIDTH-1:0]          disp_pc,
    output logic [INSTR_WIDTH-1:0]       disp_instr,
    output logic signed [DATA_WIDTH-1:0] disp_result,
    output logic                         disp_halt,
    output logic                         disp_error,
    output logic [PTR_W-1:0]             disp_offset,
    output logic                         live,
    output logic [PTR_W:0]               count,
    output logic                         new_toggle,
    output logic                         lost
);

    localparam int ENT_W = PC_WIDTH + INSTR_WIDTH + DATA_WIDTH + 2;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic {S_LIVE, S_BROWSE} state_t;

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [ENT_W-1:0]   r_mem [DEPTH];

    logic               r_valid, r_halt, r_error, r_live, r_toggle, r_lost;
    logic [PC_WIDTH-1:0]          r_pc;
    logic [INSTR_WIDTH-1:0]       r_instr;
    logic signed [DATA_WIDTH-1:0] r_result;
    logic [PTR_W-1:0]             r_offset;

    logic               w_full, w_lost;
    logic [PTR_W-1:0]   w_wr_nxt, w_rd_cap, w_rd_nxt, w_off_cap, w_off_nxt;
    logic [PTR_W:0]     w_cnt_nxt;
    logic [ENT_W-1:0]   w_cap_entry, w_rd_entry;

    assign w_cap_entry = {cap_pc, cap_instr, cap_result, cap_halt, cap_error};

    always_ff @(posedge clk) begin
        if (cap_valid)
            r_mem[r_wr_ptr] <= w_cap_entry;
    end

    // Capture is resolved first; navigation then sees post-capture count/offset.
    always_comb begin
        w_full      = (r_count == CNT_FULL);
        w_wr_nxt    = cap_valid ? r_wr_ptr + 1'b1 : r_wr_ptr;
        w_cnt_nxt   = (cap_valid && !w_full) ? r_count + 1'b1 : r_count;
        w_rd_cap    = r_rd_ptr;
        w_lost      = 1'b0;
        if (r_state == S_BROWSE && cap_valid && w_full && r_wr_ptr == r_rd_ptr) begin
            w_rd_cap = r_rd_ptr + 1'b1;
            w_lost   = 1'b1;
        end
        w_off_cap   = w_wr_nxt - w_rd_cap - PTR_W'(1);
        w_state_nxt = r_state;
        w_rd_nxt    = w_rd_cap;

        if (nav_live) begin
            w_state_nxt = S_LIVE;
        end else if (nav_back) begin
            if (r_state == S_LIVE) begin
                if (w_cnt_nxt >= (PTR_W+1)'(2)) begin
                    w_state_nxt = S_BROWSE;
                    w_rd_nxt    = w_wr_nxt - PTR_W'(2);
                end
            end else if ({1'b0, w_off_cap} < w_cnt_nxt - 1'b1) begin
                w_rd_nxt = w_rd_cap - 1'b1;
            end
        end else if (nav_fwd && r_state == S_BROWSE) begin
            if (w_off_cap > PTR_W'(1))
                w_rd_nxt = w_rd_cap + 1'b1;
            else
                w_state_nxt = S_LIVE;
        end

        if (w_state_nxt == S_LIVE)
            w_rd_nxt = w_wr_nxt - 1'b1;
        w_off_nxt = (w_state_nxt == S_LIVE) ? '0 : w_wr_nxt - w_rd_nxt - PTR_W'(1);

        // Bypass: the newest entry is written on the same edge the output register loads.
        w_rd_entry = (cap_valid && w_rd_nxt == r_wr_ptr) ? w_cap_entry : r_mem[w_rd_nxt];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_LIVE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_instr  <= '0;
            r_result <= '0;
            r_halt   <= 1'b0;
            r_error  <= 1'b0;
            r_offset <= '0;
            r_live   <= 1'b1;
            r_toggle <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_valid  <= (w_cnt_nxt != '0);
            if (w_cnt_nxt != '0)
                {r_pc, r_instr, r_result, r_halt, r_error} <= w_rd_entry;
            else
                {r_pc, r_instr, r_result, r_halt, r_error} <= '0;
            r_offset <= w_off_nxt;
            r_live   <= (w_state_nxt == S_LIVE);
            r_toggle <= r_toggle ^ cap_valid;
            r_lost   <= w_lost;
        end
    end

    assign disp_valid  = r_valid;
    assign disp_pc     = r_pc;
    assign disp_instr  = r_instr;
    assign disp_result = r_result;
    assign disp_halt   = r_halt;
    assign disp_error  = r_error;
    assign disp_offset = r_offset;
    assign live        = r_live;
    assign count       = r_count;
    assign new_toggle  = r_toggle;
    assign lost        = r_lost;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer (DEPTH=4) with a sequence-number history model.
module tb_cpu_trace_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cap_valid = 1'b0, cap_halt = 1'b0, cap_error = 1'b0;
    logic [7:0]  cap_pc = '0;
    logic [15:0] cap_instr = '0;
    logic signed [31:0] cap_result = '0;
    logic nav_back = 1'b0, nav_fwd = 1'b0, nav_live = 1'b0;

    logic disp_valid, disp_halt, disp_error, live, new_toggle, lost;
    logic [7:0]  disp_pc;
    logic [15:0] disp_instr;
    logic signed [31:0] disp_result;
    logic [PTR_W-1:0] disp_offset;
    logic [PTR_W:0]   count;

    int n_cmp = 0;
    int n_fail = 0;

    cpu_trace_buffer #(.PC_WIDTH(8), .INSTR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_result(cap_result),
        .cap_halt(cap_halt), .cap_error(cap_error),
        .nav_back(nav_back), .nav_fwd(nav_fwd), .nav_live(nav_live),
        .disp_valid(disp_valid), .disp_pc(disp_pc), .disp_instr(disp_instr),
        .disp_result(disp_result), .disp_halt(disp_halt), .disp_error(disp_error),
        .disp_offset(disp_offset), .live(live), .count(count),
        .new_toggle(new_toggle), .lost(lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: every capture gets a sequence number; the view is a sequence number too.
    typedef struct { logic [7:0] pc; logic [15:0] instr; logic signed [31:0] res; logic h; logic e; } ent_t;
    ent_t hist[$];
    bit   m_browse;
    int   m_view;
    logic e_valid, e_halt, e_error, e_live, e_tog, e_lost;
    logic [7:0] e_pc;
    logic [15:0] e_instr;
    logic signed [31:0] e_res;
    int e_off, e_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            m_browse = 0; m_view = 0;
            e_valid = 0; e_pc = 0; e_instr = 0; e_res = 0; e_halt = 0; e_error = 0;
            e_off = 0; e_cnt = 0; e_live = 1; e_tog = 0; e_lost = 0;
        end else begin
            int tot, cnt, oldest, off;
            ent_t en;
            e_lost = 0;
            if (cap_valid) begin
                en.pc = cap_pc; en.instr = cap_instr; en.res = cap_result;
                en.h = cap_halt; en.e = cap_error;
                hist.push_back(en);
                e_tog = ~e_tog;
            end
            tot = hist.size();
            cnt = (tot < DEPTH) ? tot : DEPTH;
            oldest = tot - cnt;
            if (m_browse && m_view < oldest) begin
                m_view = oldest;
                e_lost = 1;
            end
            off = m_browse ? tot - 1 - m_view : 0;
            if (nav_live) m_browse = 0;
            else if (nav_back) begin
                if (!m_browse) begin
                    if (cnt >= 2) begin m_browse = 1; m_view = tot - 2; end
                end else if (off < cnt - 1) m_view--;
            end else if (nav_fwd && m_browse) begin
                if (off > 1) m_view++;
                else m_browse = 0;
            end
            if (!m_browse) m_view = tot - 1;
            e_cnt = cnt;
            e_valid = (cnt > 0);
            if (cnt > 0) begin
                e_pc = hist[m_view].pc; e_instr = hist[m_view].instr; e_res = hist[m_view].res;
                e_halt = hist[m_view].h; e_error = hist[m_view].e;
            end else begin
                e_pc = 0; e_instr = 0; e_res = 0; e_halt = 0; e_error = 0;
            end
            e_off = m_browse ? tot - 1 - m_view : 0;
            e_live = !m_browse;
        end
    end

    always @(negedge clk) begin
        chk("m_valid", disp_valid, e_valid);
        chk("m_pc", disp_pc, e_pc);
        chk("m_instr", disp_instr, e_instr);
        chk("m_result", disp_result, e_res);
        chk("m_halt", disp_halt, e_halt);
        chk("m_error", disp_error, e_error);
        chk("m_offset", disp_offset, e_off);
        chk("m_live", live, e_live);
        chk("m_count", count, e_cnt);
        chk("m_toggle", new_toggle, e_tog);
        chk("m_lost", lost, e_lost);
    end

    task automatic cyc(input bit c, input logic [7:0] pc, input logic signed [31:0] res,
                       input bit h, input bit e, input bit b, input bit f, input bit l);
        cap_valid = c; cap_pc = pc; cap_instr = {8'hA0, pc}; cap_result = res;
        cap_halt = h; cap_error = e; nav_back = b; nav_fwd = f; nav_live = l;
        @(posedge clk); #1;
        cap_valid = 0; nav_back = 0; nav_fwd = 0; nav_live = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("rst_count", count, 0);
        chk("rst_live", live, 1);
        chk("rst_valid", disp_valid, 0);

        // Three captures, newest shown live
        cyc(1, 8'd1, -5, 0, 1, 0, 0, 0);
        chk("t1_pc_first", disp_pc, 1);
        chk("t1_res_first", disp_result, -5);
        cyc(1, 8'd2, 10, 0, 0, 0, 0, 0);
        cyc(1, 8'd3, 20, 1, 0, 0, 0, 0);
        chk("t1_count", count, 3);
        chk("t1_live", live, 1);
        chk("t1_pc", disp_pc, 3);
        chk("t1_res", disp_result, 20);
        chk("t1_halt", disp_halt, 1);
        chk("t1_toggle", new_toggle, 1);

        // Browse back with saturation, then forward to live
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t2_off1", disp_offset, 1); chk("t2_pc2", disp_pc, 2); chk("t2_live0", live, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t2_off2", disp_offset, 2); chk("t2_pc1", disp_pc, 1); chk("t2_err", disp_error, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t2_sat_off", disp_offset, 2); chk("t2_sat_pc", disp_pc, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("t2_fwd_off", disp_offset, 1); chk("t2_fwd_pc", disp_pc, 2);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("t2_back_live", live, 1); chk("t2_live_pc", disp_pc, 3); chk("t2_live_off", disp_offset, 0);

        // Wrap, browse to oldest, overwrite while browsing
        cyc(1, 8'd4, 40, 0, 0, 0, 0, 0);
        cyc(1, 8'd5, 50, 0, 0, 0, 0, 0);
        cyc(1, 8'd6, 60, 0, 0, 0, 0, 0);
        chk("t3_count", count, 4); chk("t3_pc6", disp_pc, 6);
        repeat (3) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t3_pc3", disp_pc, 3); chk("t3_off3", disp_offset, 3);
        cyc(1, 8'd7, 70, 0, 0, 0, 0, 0);
        chk("t3_lost", lost, 1); chk("t3_pc4", disp_pc, 4); chk("t3_off_keep", disp_offset, 3);
        chk("t3_res4", disp_result, 40);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_lost_clr", lost, 0); chk("t3_pc4_hold", disp_pc, 4);

        // Capture while browsing keeps the displayed entry
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_live", live, 1); chk("t4_pc7", disp_pc, 7);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t4_pc6", disp_pc, 6); chk("t4_off1", disp_offset, 1);
        cyc(1, 8'd8, 80, 0, 0, 0, 0, 0);
        chk("t4_pc_keep", disp_pc, 6); chk("t4_off2", disp_offset, 2); chk("t4_live0", live, 0);
        chk("t4_nolost", lost, 0);

        // Small counts and same-cycle capture+nav
        reset = 1; #1; reset = 0;
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t5_empty_back", live, 1); chk("t5_empty_valid", disp_valid, 0);
        cyc(1, 8'h11, 100, 0, 0, 1, 0, 0);
        chk("t5_cnt1_back", live, 1); chk("t5_pc11", disp_pc, 8'h11);
        cyc(1, 8'h12, -200, 0, 1, 1, 0, 0);
        chk("t5_browse", live, 0); chk("t5_off1", disp_offset, 1); chk("t5_pc_first", disp_pc, 8'h11);
        chk("t5_instr", disp_instr, 16'hA011);
        cyc(0, 0, 0, 0, 0, 1, 0, 1);
        chk("t5_livepri", live, 1); chk("t5_pc12", disp_pc, 8'h12); chk("t5_res", disp_result, -200);

        // Reset in the middle of browsing
        cyc(1, 8'h13, 1, 0, 0, 0, 0, 0);
        cyc(1, 8'h14, 2, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t6_pre_count", count, 4); chk("t6_pre_live", live, 0);
        @(posedge clk); #2;
        reset = 1; #1;
        chk("t6_count", count, 0); chk("t6_valid", disp_valid, 0); chk("t6_live", live, 1);
        chk("t6_pc", disp_pc, 0); chk("t6_res", disp_result, 0); chk("t6_off", disp_offset, 0);
        chk("t6_tog", new_toggle, 0);
        @(posedge clk); #1 reset = 0;
        cyc(1, 8'h21, 7, 1, 1, 0, 0, 0);
        chk("t6_after_pc", disp_pc, 8'h21); chk("t6_after_tog", new_toggle, 1); chk("t6_after_cnt", count, 1);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
